interrupt_controller: RTL and testbench
=======================================

// Module: interrupt_controller
// PURPOSE
//  Collects single-cycle interrupt pulses from memory-mapped I/O devices (switch input, timers, UART) and
//   presents one prioritised, maskable interrupt to the CPU.
//  Software reads and writes four registers over the shared 32-bit tri-state data bus (read/write strobes).
//  Handshake with the CPU: request -> ack -> end-of-interrupt (EOI).
// PARAMETERS
//  NUM_SOURCES  4   number of interrupt inputs, 1..8; bit 0 is the highest priority
// PORTS
//  clock        in     1            system clock, all state on rising edge
//  reset        in     1            asynchronous, active-low; all state cleared while low
//  data         inout  32           register bus; driven only when read=1, else 32'bZ
//  addr         in     2            register select: 0 PENDING, 1 MASK, 2 VECTOR, 3 CTRL
//  read         in     1            combinational read enable
//  write        in     1            write strobe, sampled on the clock edge
//  irqIn        in     NUM_SOURCES  per-source pulses (already debounced/pulsed)
//  cpuInterrupt out    1            registered request to CPU
//  cpuAck       in     1            1-cycle pulse: CPU has taken the interrupt
// BEHAVIOUR
//  Registers (unused upper bits read 0):
//   PENDING[N-1:0]  R/W1C; bit set on irqIn pulse, cleared by writing 1 or on ack of that source
//   MASK[N-1:0]     R/W; 1 = source enabled; reset 0 (all masked)
//   VECTOR[2:0]     R; index of latched/in-service source; [31] = inService flag
//   CTRL            W: bit0 = global enable (reads back), bit1 = EOI (write-only pulse, reads 0)
//  Reset: PENDING=0, MASK=0, enable=0, vector=0, state=IDLE, cpuInterrupt=0.
//  Eligible = PENDING & MASK & {N{enable}}. Winner = lowest set index (priority encoder).
//  FSM:
//   IDLE    : Eligible != 0 -> REQUEST, latch winner into vector
//   REQUEST : cpuInterrupt=1; cpuAck -> SERVICE, clear PENDING[vector], inService=1;
//             latched bit no longer eligible (masked, disabled or W1C) before ack -> IDLE, no ack expected
//   SERVICE : cpuInterrupt=0; EOI write -> IDLE, inService=0; no nesting
//  cpuInterrupt is a registered output equal to (state==REQUEST).
//  Latency: irqIn pulse sampled at edge k -> PENDING set after k -> REQUEST and cpuInterrupt=1 after k+1.
//  Vector is frozen once latched. A higher-priority arrival during REQUEST does not pre-empt;
//   it is serviced next.
//  Simultaneous-event rules:
//   irqIn pulse and W1C of the same bit in one cycle: set wins.
//   irqIn pulse and ack of the same source in one cycle: bit stays set (new event is kept).
//   irqIn of the in-service source during SERVICE: re-pends; requested again after EOI.
//   cpuAck outside REQUEST: ignored. EOI outside SERVICE: ignored.
//   EOI written together with enable=0: EOI still honoured.
//  Reset asserted mid-handshake: cpuInterrupt drops immediately; all pending events are lost.
// STRUCTURE
//  Shared package constants: register addresses (PENDING/MASK/VECTOR/CTRL), CTRL bit positions,
//   FSM state encoding.
//  One sub-module, int_priority_encoder: combinational, N-bit in -> 3-bit index plus valid, lowest index wins.
//  Top level holds the registers, the FSM and the bus read mux.
// TESTING
//  1 Reset: reset=0 with irqIn=4'b1111 -> PENDING=0, cpuInterrupt=0, data=Z with read=0.
//  2 Basic flow: MASK=4'b0100, CTRL=1, pulse irqIn[2] -> cpuInterrupt=1 two edges later;
//    VECTOR reads 2; cpuAck -> cpuInterrupt=0, PENDING=0, VECTOR[31]=1;
//    EOI -> IDLE, VECTOR[31]=0.
//  3 Priority: MASK=4'b1111, pulse irqIn[3] and irqIn[1] in the same cycle -> VECTOR=1;
//    after ack and EOI -> second request with VECTOR=3.
//  4 Masking and withdrawal: pulse irqIn[0] with MASK=0 -> no request, PENDING=1;
//    set MASK=1 -> request; clear MASK in REQUEST -> cpuInterrupt falls, PENDING stays 1.
//  5 Collision rules: W1C of bit 2 plus irqIn[2] in the same cycle -> PENDING[2]=1;
//    irqIn[2] during SERVICE of source 2 -> new request one edge after EOI.
//  6 Reset mid-REQUEST: drop reset in REQUEST -> cpuInterrupt=0 asynchronously, state IDLE, MASK=0.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller: bus geometry, register
// addresses, CTRL bit positions and the handshake FSM encoding.
package interrupt_controller_pkg;

  localparam int BUS_WIDTH   = 32;
  localparam int VEC_WIDTH   = 3;
  localparam int MAX_SOURCES = 1 << VEC_WIDTH;

  // Register map
  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_VECTOR  = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  // CTRL register bits
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_EOI_BIT    = 1;

  // VECTOR register: in-service flag position
  localparam int VEC_INSERVICE_BIT = BUS_WIDTH - 1;

  // Handshake FSM states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQUEST = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// int_priority_encoder: combinational lowest-index-wins priority encoder.
// valid is high when any request bit is set; index is 0 when none is.
module int_priority_encoder
  import interrupt_controller_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]     req,
  output logic [VEC_WIDTH-1:0] index,
  output logic                 valid
);

  // Scan from the top down so the lowest set bit is the last (winning) assignment.
  always_comb begin
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        index = VEC_WIDTH'(i);
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: latches interrupt pulses into PENDING, filters them
// through MASK and the global enable, and runs a request/ack/EOI handshake
// with the CPU for the highest-priority (lowest-index) eligible source.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int NUM_SOURCES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  inout  wire  [BUS_WIDTH-1:0]   data,
  input  logic [1:0]             addr,
  input  logic                   read,
  input  logic                   write,
  input  logic [NUM_SOURCES-1:0] irqIn,
  output logic                   cpuInterrupt,
  input  logic                   cpuAck
);

  // Registered state
  logic [NUM_SOURCES-1:0] pending;
  logic [NUM_SOURCES-1:0] mask;
  logic                   enable;
  logic [VEC_WIDTH-1:0]   vector;
  logic [1:0]             state;
  logic                   cpu_interrupt_reg;

  // Next-state values
  logic [NUM_SOURCES-1:0] pending_next;
  logic [VEC_WIDTH-1:0]   vector_next;
  logic [1:0]             state_next;

  // Decoded bus writes
  logic wr_pending;
  logic wr_mask;
  logic wr_ctrl;
  logic eoi;

  // Arbitration
  logic [NUM_SOURCES-1:0] eligible;
  logic [NUM_SOURCES-1:0] vector_sel;
  logic [NUM_SOURCES-1:0] ack_clear;
  logic [NUM_SOURCES-1:0] w1c_clear;
  logic [VEC_WIDTH-1:0]   winner;
  logic                   winner_valid;
  logic                   latched_eligible;
  logic                   ack_taken;
  logic                   in_service;

  // Bus read data
  logic [BUS_WIDTH-1:0]   rdata;

  // Only data[N-1:0] and the CTRL bits are ever written; fold the rest away.
  logic                   unused_bus;
  assign unused_bus = ^data;

  assign wr_pending = write && (addr == ADDR_PENDING);
  assign wr_mask    = write && (addr == ADDR_MASK);
  assign wr_ctrl    = write && (addr == ADDR_CTRL);
  assign eoi        = wr_ctrl && data[CTRL_EOI_BIT];

  assign eligible   = pending & mask & {NUM_SOURCES{enable}};
  assign in_service = (state == ST_SERVICE);
  assign ack_taken  = (state == ST_REQUEST) && cpuAck;
  assign w1c_clear  = wr_pending ? data[NUM_SOURCES-1:0] : '0;

  int_priority_encoder #(
    .WIDTH (NUM_SOURCES)
  ) u_prio (
    .req   (eligible),
    .index (winner),
    .valid (winner_valid)
  );

  // Per-source decode of the latched vector, and the PENDING update rule:
  // a new pulse always wins over a W1C or ack clear in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SOURCES; gi++) begin : g_source
      assign vector_sel[gi]   = (vector == VEC_WIDTH'(gi));
      assign ack_clear[gi]    = ack_taken && vector_sel[gi];
      assign pending_next[gi] = irqIn[gi] |
                                (pending[gi] & ~w1c_clear[gi] & ~ack_clear[gi]);
    end
  endgenerate

  // The latched source withdraws if it stops being eligible while requesting.
  assign latched_eligible = |(eligible & vector_sel);

  // Handshake FSM: pick a winner in IDLE, hold the request until ack or
  // withdrawal, then wait for EOI. The vector is frozen outside IDLE.
  always_comb begin
    state_next  = state;
    vector_next = vector;
    case (state)
      ST_IDLE: begin
        if (winner_valid) begin
          state_next  = ST_REQUEST;
          vector_next = winner;
        end
      end
      ST_REQUEST: begin
        if (cpuAck) begin
          state_next = ST_SERVICE;
        end else if (!latched_eligible) begin
          state_next = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Register update for handshake state, software registers and the CPU request line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= ST_IDLE;
      vector            <= '0;
      pending           <= '0;
      mask              <= '0;
      enable            <= 1'b0;
      cpu_interrupt_reg <= 1'b0;
    end else begin
      state             <= state_next;
      vector            <= vector_next;
      pending           <= pending_next;
      cpu_interrupt_reg <= (state_next == ST_REQUEST);
      if (wr_mask) begin
        mask <= data[NUM_SOURCES-1:0];
      end
      if (wr_ctrl) begin
        enable <= data[CTRL_ENABLE_BIT];
      end
    end
  end

  assign cpuInterrupt = cpu_interrupt_reg;

  // Register read mux; unused upper bits read as zero, EOI reads as zero.
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_PENDING: rdata = BUS_WIDTH'(pending);
      ADDR_MASK:    rdata = BUS_WIDTH'(mask);
      ADDR_VECTOR: begin
        rdata                    = BUS_WIDTH'(vector);
        rdata[VEC_INSERVICE_BIT] = in_service;
      end
      ADDR_CTRL:    rdata = BUS_WIDTH'(enable);
      default:      rdata = '0;
    endcase
  end

  assign data = read ? rdata : {BUS_WIDTH{1'bz}};

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios followed
// by randomized traffic compared against a behavioural model of the rules.
module tb_interrupt_controller;
  import interrupt_controller_pkg::*;

  localparam int N = 4;

  logic         clock;
  logic         reset;
  wire  [31:0]  data;
  logic [1:0]   addr;
  logic         read;
  logic         write;
  logic [N-1:0] irqIn;
  logic         cpuInterrupt;
  logic         cpuAck;

  logic [31:0]  bus_out;
  logic         bus_oe;

  int tests_run;
  int tests_failed;

  // Behavioural model state
  logic [N-1:0] m_pending;
  logic [N-1:0] m_mask;
  bit           m_enable;
  bit           m_req;
  bit           m_svc;
  int           m_vec;

  assign data = bus_oe ? bus_out : 32'bz;

  interrupt_controller #(.NUM_SOURCES(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .data         (data),
    .addr         (addr),
    .read         (read),
    .write        (write),
    .irqIn        (irqIn),
    .cpuInterrupt (cpuInterrupt),
    .cpuAck       (cpuAck)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic model_reset();
    m_pending = '0;
    m_mask    = '0;
    m_enable  = 1'b0;
    m_req     = 1'b0;
    m_svc     = 1'b0;
    m_vec     = 0;
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [N-1:0] p;
    logic [N-1:0] elig;
    bit           eoi;
    if (!reset) begin
      model_reset();
      return;
    end
    p    = m_pending;
    elig = m_pending & m_mask & {N{m_enable}};
    eoi  = write && (addr == ADDR_CTRL) && bus_out[1];
    if (m_req) begin
      if (cpuAck) begin
        m_req    = 1'b0;
        m_svc    = 1'b1;
        p[m_vec] = 1'b0;
      end else if (!elig[m_vec]) begin
        m_req = 1'b0;
      end
    end else if (m_svc) begin
      if (eoi) m_svc = 1'b0;
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (elig[i]) begin
          m_req = 1'b1;
          m_vec = i;
        end
      end
    end
    if (write && addr == ADDR_PENDING) p = p & ~bus_out[N-1:0];
    p = p | irqIn;
    m_pending = p;
    if (write && addr == ADDR_MASK) m_mask = bus_out[N-1:0];
    if (write && addr == ADDR_CTRL) m_enable = bus_out[0];
  endtask

  function automatic logic [31:0] m_vector_word();
    return {m_svc, 28'd0, 3'(m_vec)};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    read = 1'b1;
    #1;
    v = data;
    read = 1'b0;
    #1;
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  // With read low nobody drives the bus: high-Z (or 0 in a two-state simulator).
  task automatic chk_float(input string tag);
    read = 1'b0;
    #1;
    tests_run++;
    assert ((data === 32'bz) || (data === 32'b0)) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected zzzzzzzz", tag, data);
    end
  endtask

  task automatic wr_irq(input logic [1:0] a, input logic [31:0] v, input logic [N-1:0] irq);
    addr    = a;
    bus_out = v;
    bus_oe  = 1'b1;
    write   = 1'b1;
    irqIn   = irq;
    tick();
    write  = 1'b0;
    bus_oe = 1'b0;
    irqIn  = '0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    wr_irq(a, v, '0);
  endtask

  task automatic pulse(input logic [N-1:0] irq);
    irqIn = irq;
    tick();
    irqIn = '0;
  endtask

  task automatic ack_irq(input logic [N-1:0] irq);
    cpuAck = 1'b1;
    irqIn  = irq;
    tick();
    cpuAck = 1'b0;
    irqIn  = '0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset   = 1'b0;
    addr    = '0;
    read    = 1'b0;
    write   = 1'b0;
    irqIn   = '1;
    cpuAck  = 1'b0;
    bus_out = '0;
    bus_oe  = 1'b0;
    model_reset();

    // 1: reset holds everything clear even with pulses present
    tick(); tick(); tick();
    chk("rst_irq", 32'(cpuInterrupt), 32'd0);
    chk_rd("rst_pending", ADDR_PENDING, 32'd0);
    chk_rd("rst_mask", ADDR_MASK, 32'd0);
    chk_rd("rst_vector", ADDR_VECTOR, 32'd0);
    chk_float("rst_bus_z");
    irqIn = '0;
    reset = 1'b1;
    tick();

    // 2: basic flow on source 2
    wr(ADDR_MASK, 32'h4);
    addr = ADDR_MASK;
    chk_float("bus_z_mask");
    wr(ADDR_CTRL, 32'h1);
    chk_rd("ctrl_rb", ADDR_CTRL, 32'h1);
    pulse(4'b0100);
    chk("basic_lat1", 32'(cpuInterrupt), 32'd0);
    tick();
    chk("basic_lat2", 32'(cpuInterrupt), 32'd1);
    chk_rd("basic_vec", ADDR_VECTOR, 32'h2);
    ack_irq('0);
    chk("basic_ack_irq", 32'(cpuInterrupt), 32'd0);
    chk_rd("basic_ack_pend", ADDR_PENDING, 32'd0);
    chk_rd("basic_ack_vec", ADDR_VECTOR, 32'h8000_0002);
    wr(ADDR_CTRL, 32'h3);
    chk_rd("basic_eoi_vec", ADDR_VECTOR, 32'h2);
    chk("basic_eoi_irq", 32'(cpuInterrupt), 32'd0);

    // 3: priority between simultaneous sources
    wr(ADDR_MASK, 32'hF);
    pulse(4'b1010);
    tick();
    chk("prio_irq", 32'(cpuInterrupt), 32'd1);
    chk_rd("prio_vec1", ADDR_VECTOR, 32'h1);
    ack_irq('0);
    chk_rd("prio_pend", ADDR_PENDING, 32'h8);
    wr(ADDR_CTRL, 32'h3);
    tick();
    chk("prio_irq2", 32'(cpuInterrupt), 32'd1);
    chk_rd("prio_vec3", ADDR_VECTOR, 32'h3);
    ack_irq('0);
    wr(ADDR_CTRL, 32'h3);
    chk_rd("prio_pend0", ADDR_PENDING, 32'd0);

    // 4: masking and withdrawal
    wr(ADDR_MASK, 32'h0);
    pulse(4'b0001);
    tick();
    chk("mask_noreq", 32'(cpuInterrupt), 32'd0);
    chk_rd("mask_pend", ADDR_PENDING, 32'h1);
    wr(ADDR_MASK, 32'h1);
    tick();
    chk("mask_req", 32'(cpuInterrupt), 32'd1);
    chk_rd("mask_vec", ADDR_VECTOR, 32'h0);
    wr(ADDR_MASK, 32'h0);
    chk("wd_hold", 32'(cpuInterrupt), 32'd1);
    tick();
    chk("wd_drop", 32'(cpuInterrupt), 32'd0);
    chk_rd("wd_pend", ADDR_PENDING, 32'h1);
    wr(ADDR_PENDING, 32'h1);
    chk_rd("w1c_pend", ADDR_PENDING, 32'h0);

    // 5: collision rules
    pulse(4'b0100);
    wr_irq(ADDR_PENDING, 32'h4, 4'b0100);
    chk_rd("col_w1c_set", ADDR_PENDING, 32'h4);
    wr(ADDR_MASK, 32'h4);
    tick();
    chk("col_req", 32'(cpuInterrupt), 32'd1);
    ack_irq(4'b0100);
    chk_rd("col_ack_set", ADDR_PENDING, 32'h4);
    chk_rd("col_svc_vec", ADDR_VECTOR, 32'h8000_0002);
    pulse(4'b0100);
    ack_irq('0);
    chk("col_svc_irq", 32'(cpuInterrupt), 32'd0);
    chk_rd("col_svc_ackign", ADDR_PENDING, 32'h4);
    wr(ADDR_CTRL, 32'h3);
    chk("col_eoi_irq", 32'(cpuInterrupt), 32'd0);
    tick();
    chk("col_rereq", 32'(cpuInterrupt), 32'd1);
    chk_rd("col_rereq_vec", ADDR_VECTOR, 32'h2);
    ack_irq('0);
    wr(ADDR_CTRL, 32'h2);
    chk_rd("eoi_dis_vec", ADDR_VECTOR, 32'h2);
    chk_rd("eoi_dis_ctrl", ADDR_CTRL, 32'h0);
    wr(ADDR_CTRL, 32'h1);

    // 6: reset in the middle of a request
    wr(ADDR_MASK, 32'h1);
    pulse(4'b0001);
    tick();
    chk("rst6_req", 32'(cpuInterrupt), 32'd1);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst6_async", 32'(cpuInterrupt), 32'd0);
    tick();
    chk_rd("rst6_mask", ADDR_MASK, 32'd0);
    chk_rd("rst6_pend", ADDR_PENDING, 32'd0);
    chk_rd("rst6_vec", ADDR_VECTOR, 32'd0);
    reset = 1'b1;
    tick();
    chk("rst6_idle", 32'(cpuInterrupt), 32'd0);

    // 7: randomized traffic against the model
    wr(ADDR_CTRL, 32'h1);
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [31:0] v;
      int op;
      irqIn = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      op = int'($urandom_range(0, 9));
      if (m_svc && $urandom_range(0, 5) == 0) begin
        write = 1'b1; bus_oe = 1'b1; addr = ADDR_CTRL;
        bus_out = {$urandom, 1'b1, 1'b1} >> 0;
        bus_out[1:0] = 2'b11;
      end else if (op < 2) begin
        write = 1'b1; bus_oe = 1'b1;
        addr = 2'($urandom);
        bus_out = $urandom;
        if (addr == ADDR_CTRL) bus_out[0] = ($urandom_range(0, 3) != 0);
      end
      if (m_req && m_pending[m_vec] && m_mask[m_vec] && m_enable)
        cpuAck = $urandom_range(0, 1) == 1;
      else if (!m_req)
        cpuAck = $urandom_range(0, 9) == 0;
      tick();
      write = 1'b0; bus_oe = 1'b0; irqIn = '0; cpuAck = 1'b0;
      chk("rnd_irq", 32'(cpuInterrupt), 32'(m_req));
      rd(ADDR_PENDING, v);
      chk("rnd_pend", v, 32'(m_pending));
      rd(ADDR_VECTOR, v);
      chk("rnd_vec", v, m_vector_word());
      rd(ADDR_MASK, v);
      chk("rnd_mask", v, 32'(m_mask));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
